// File: rtl/bcd_display_scan.sv
// ----------------------------------------------------------------------------
// bcd_display_scan
//
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Each frame starts with a one-cycle LOAD that snapshots the BCD digits and
// decimal points. Each digit is then lit for PRESCALE cycles (SHOW), followed
// by BLANK_CYCLES cycles with every anode off (GAP). The next digit's code is
// presented during GAP, so the BCD bus never changes while an anode is on.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_en         scan enable; low forces the display dark and returns to IDLE
//   i_digits_in  packed BCD, digit k = bits [4k+3:4k]
//   i_dp_in      decimal point per digit, active high
//   i_lz_blank   leading-zero suppression enable (sampled live)
//   o_bcd_out    current digit code to the BCD-to-7-segment decoder
//   o_dp_out     decimal point of the current digit
//   o_an_n       anode enables, active low, one-hot-low or all high
//   o_frame_tick one-cycle pulse in the LOAD cycle that follows a full frame
// ----------------------------------------------------------------------------
module bcd_display_scan #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned PRESCALE     = 100000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [4*DIGITS-1:0]   i_digits_in,
    input  logic [DIGITS-1:0]     i_dp_in,
    input  logic                  i_lz_blank,
    output logic [3:0]            o_bcd_out,
    output logic                  o_dp_out,
    output logic [DIGITS-1:0]     o_an_n,
    output logic                  o_frame_tick
);

    localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CntMax = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    // The counter only ever holds 0 .. CntMax-1.
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] ShowLast = CntW'(PRESCALE - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(BLANK_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(DIGITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShow,
        StGap
    } state_e;

    state_e                r_state;
    logic [IdxW-1:0]       r_index;
    logic [CntW-1:0]       r_cnt;
    logic [4*DIGITS-1:0]   r_snap_digits;
    logic [DIGITS-1:0]     r_snap_dp;
    logic [3:0]            r_bcd;
    logic                  r_dp;
    logic [DIGITS-1:0]     r_an_n;
    logic                  r_frame_tick;

    logic [3:0]            w_snap_digit [DIGITS];
    logic [DIGITS-1:0]     w_zero_from;
    logic [IdxW-1:0]       w_idx_next;
    logic                  w_last;

    // w_zero_from[k] is set when snapshot digits k .. DIGITS-1 are all zero.
    always_comb begin
        logic zero_acc;
        zero_acc    = 1'b1;
        w_zero_from = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            w_snap_digit[k] = r_snap_digits[4*k +: 4];
        end
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            zero_acc       = zero_acc && (w_snap_digit[k] == 4'd0);
            w_zero_from[k] = zero_acc;
        end
    end

    assign w_idx_next = r_index + IdxW'(1);
    assign w_last     = (r_index == IdxLast);

    // Anode pattern for a SHOW slot; digit 0 is never suppressed.
    function automatic logic [DIGITS-1:0] lit_pattern(
        input logic [IdxW-1:0]   idx,
        input logic              lz,
        input logic [DIGITS-1:0] zero_from
    );
        logic [DIGITS-1:0] pat;
        pat = '1;
        if (!(lz && (idx != '0) && zero_from[idx])) begin
            pat[idx] = 1'b0;
        end
        return pat;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_index       <= '0;
            r_cnt         <= '0;
            r_snap_digits <= '0;
            r_snap_dp     <= '0;
            r_bcd         <= 4'd0;
            r_dp          <= 1'b0;
            r_an_n        <= '1;
            r_frame_tick  <= 1'b0;
        end else if (!i_en) begin
            // Dark and idle; the BCD bus and decimal point keep their value.
            r_state      <= StIdle;
            r_index      <= '0;
            r_cnt        <= '0;
            r_an_n       <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // Capture on entry so the LOAD cycle already carries digit 0.
                    r_state       <= StLoad;
                    r_index       <= '0;
                    r_cnt         <= '0;
                    r_an_n        <= '1;
                    r_snap_digits <= i_digits_in;
                    r_snap_dp     <= i_dp_in;
                    r_bcd         <= i_digits_in[3:0];
                    r_dp          <= i_dp_in[0];
                end
                StLoad: begin
                    r_state <= StShow;
                    r_cnt   <= '0;
                    r_an_n  <= lit_pattern(r_index, i_lz_blank, w_zero_from);
                end
                StShow: begin
                    if (r_cnt == ShowLast) begin
                        r_state <= StGap;
                        r_cnt   <= '0;
                        r_an_n  <= '1;
                        // Present the next digit while every anode is off.
                        if (!w_last) begin
                            r_bcd <= w_snap_digit[w_idx_next];
                            r_dp  <= r_snap_dp[w_idx_next];
                        end
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_an_n <= lit_pattern(r_index, i_lz_blank, w_zero_from);
                    end
                end
                StGap: begin
                    if (r_cnt == GapLast) begin
                        r_cnt <= '0;
                        if (w_last) begin
                            r_state       <= StLoad;
                            r_frame_tick  <= 1'b1;
                            r_index       <= '0;
                            r_an_n        <= '1;
                            r_snap_digits <= i_digits_in;
                            r_snap_dp     <= i_dp_in;
                            r_bcd         <= i_digits_in[3:0];
                            r_dp          <= i_dp_in[0];
                        end else begin
                            r_state <= StShow;
                            r_index <= w_idx_next;
                            r_an_n  <= lit_pattern(w_idx_next, i_lz_blank, w_zero_from);
                        end
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_an_n <= '1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_an_n  <= '1;
                end
            endcase
        end
    end

    assign o_bcd_out    = r_bcd;
    assign o_dp_out     = r_dp;
    assign o_an_n       = r_an_n;
    assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_bcd_display_scan.sv
// ----------------------------------------------------------------------------
// tb_bcd_display_scan
//
// Self-checking bench for bcd_display_scan (DIGITS=4, PRESCALE=4,
// BLANK_CYCLES=2). A reference model tracks the position inside the frame and
// derives every output from that position with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_bcd_display_scan;

    localparam int D     = 4;
    localparam int PS    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = PS + BL;
    localparam int FRAME = D * SLOT + 1;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        lz;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  bcd;
    logic        dpo;
    logic [3:0]  an;
    logic        tick;

    bcd_display_scan #(
        .DIGITS       (D),
        .PRESCALE     (PS),
        .BLANK_CYCLES (BL)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_digits_in  (digits),
        .i_dp_in      (dp),
        .i_lz_blank   (lz),
        .o_bcd_out    (bcd),
        .o_dp_out     (dpo),
        .o_an_n       (an),
        .o_frame_tick (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_active;
    int          m_pos;      // 0 = LOAD cycle, 1.. = slot cycles
    logic [15:0] m_snap;
    logic [3:0]  m_snap_dp;
    logic [3:0]  m_bcd;
    logic        m_dp;
    logic [3:0]  m_an;
    logic        m_tick;
    logic [3:0]  prev_bcd;

    int unsigned rnd;
    logic [15:0] masks [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_pos     = 0;
        m_snap    = '0;
        m_snap_dp = '0;
        m_bcd     = '0;
        m_dp      = 1'b0;
        m_an      = 4'hF;
        m_tick    = 1'b0;
    endtask

    task automatic model_edge();
        int p;
        int slot;
        int off;
        int shown;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!en) begin
            m_active = 1'b0;
            m_tick   = 1'b0;
            m_an     = 4'hF;
            return;
        end
        m_tick = 1'b0;
        if (!m_active) begin
            m_active  = 1'b1;
            m_pos     = 0;
            m_snap    = digits;
            m_snap_dp = dp;
        end else begin
            m_pos++;
            if (m_pos == FRAME) begin
                m_pos     = 0;
                m_tick    = 1'b1;
                m_snap    = digits;
                m_snap_dp = dp;
            end
        end
        m_an = 4'hF;
        if (m_pos == 0) begin
            shown = 0;
        end else begin
            p    = m_pos - 1;
            slot = p / SLOT;
            off  = p % SLOT;
            if (off < PS) begin
                shown = slot;
                if (!(lz && slot > 0 && (m_snap >> (4 * slot)) == 16'h0)) m_an[slot] = 1'b0;
            end else begin
                shown = (slot + 1 < D) ? slot + 1 : D - 1;
            end
        end
        m_bcd = 4'((m_snap >> (4 * shown)) & 16'hF);
        m_dp  = m_snap_dp[shown];
    endtask

    task automatic check_outputs();
        check_eq("an_n", an, m_an);
        check_eq("bcd_out", bcd, m_bcd);
        check_eq("dp_out", dpo, m_dp);
        check_eq("frame_tick", tick, m_tick);
        if (bcd !== prev_bcd) check_eq("an_dark_on_bcd_change", an, 4'hF);
        prev_bcd = bcd;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Advance until the model enters the requested phase (slot < 0 = any slot).
    task automatic wait_phase(input int want_slot, input bit want_show);
        bit hit;
        int p;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            cycle();
            if (m_active && m_pos > 0) begin
                p = m_pos - 1;
                if ((want_slot < 0 || p / SLOT == want_slot) && ((p % SLOT < PS) == want_show))
                    hit = 1'b1;
            end
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_phase: slot %0d show %0d not reached", want_slot, want_show);
        end
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq({tag, "_an_n"}, an, 4'hF);
        check_eq({tag, "_bcd_out"}, bcd, 4'h0);
        check_eq({tag, "_dp_out"}, dpo, 1'b0);
        check_eq({tag, "_frame_tick"}, tick, 1'b0);
        en = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (4) cycle();
    endtask

    initial begin
        masks[0] = 16'h000F;
        masks[1] = 16'h00FF;
        masks[2] = 16'h0FFF;
        masks[3] = 16'hFFFF;
        rst_n  = 1'b0;
        en     = 1'b0;
        lz     = 1'b0;
        digits = '0;
        dp     = '0;
        model_reset();
        prev_bcd = '0;

        // Reset and idle
        #12;
        check_outputs();
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (6) cycle();

        // Plain scanning
        digits = 16'h1234;
        dp     = 4'b0100;
        en     = 1'b1;
        repeat (3 * FRAME) cycle();

        // Leading-zero suppression
        lz     = 1'b1;
        digits = 16'h0050;
        repeat (2 * FRAME) cycle();
        digits = 16'h0000;
        repeat (2 * FRAME) cycle();
        lz = 1'b0;

        // Input change mid-frame has no effect until the next LOAD
        digits = 16'h1234;
        repeat (FRAME) cycle();
        wait_phase(1, 1'b1);
        digits = 16'h9876;
        wait_phase(2, 1'b1);
        check_eq("midframe_slot2", bcd, 4'h2);
        wait_phase(3, 1'b1);
        check_eq("midframe_slot3", bcd, 4'h1);
        wait_phase(0, 1'b1);
        check_eq("newframe_slot0", bcd, 4'h6);
        check_eq("newframe_an0", an, 4'b1110);

        // Drop and re-assert enable during SHOW
        wait_phase(1, 1'b1);
        en = 1'b0;
        cycle();
        check_eq("en_drop_dark", an, 4'hF);
        en = 1'b1;
        cycle();
        check_eq("reen_load_dark", an, 4'hF);
        cycle();
        check_eq("reen_digit0", an, 4'b1110);
        repeat (FRAME) cycle();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rnd = $urandom_range(0, 99);
            if (rnd < 10) digits = 16'($urandom) & masks[$urandom_range(0, 3)];
            if (rnd >= 10 && rnd < 18) dp = 4'($urandom);
            if (rnd == 20) lz = ~lz;
            if (rnd == 30) en = 1'b0;
            if (rnd >= 31 && rnd < 50 && !en) en = 1'b1;
            cycle();
        end

        // Asynchronous reset mid-GAP and mid-SHOW
        en     = 1'b1;
        lz     = 1'b0;
        digits = 16'h1234;
        dp     = 4'b1010;
        repeat (FRAME + 1) cycle();
        wait_phase(-1, 1'b0);
        async_reset("rst_gap");
        en = 1'b1;
        repeat (FRAME + 1) cycle();
        wait_phase(-1, 1'b1);
        async_reset("rst_show");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
